brick_renderer: RTL and testbench
=================================

# brick_renderer

Reads brick records back out of the 256x18 brick RAM and rasterizes each one as a filled 16x4 rectangle on the 160x120 VGA adapter's plot interface. It consumes the RAM the store sequence fills, using the same record format: colour [17:15], y [14:8], x [7:0]. The game control FSM pulses `start` to draw the whole brick field. It then waits for `done` before doing the next draw.

## Interface
- `NUM_BRICKS`, default 40: records to draw, from addresses 0..NUM_BRICKS-1. Legal range 1..2^ADDR_W.
- `ADDR_W`, default 8: RAM address width.
- `BRICK_W`, default 16: rectangle width in pixels. Must be a power of 2.
- `BRICK_H`, default 4: rectangle height in pixels. Must be a power of 2.

Ports:
- `clk` in 1: system clock (CLOCK_50 at top).
- `resetn` in 1: reset. One clock; reset is synchronous and active-low.
- `start` in 1: request one full draw pass. Sampled only in IDLE.
- `ram_q` in 18: RAM read data. Valid one cycle after the address is presented.
- `ram_address` out ADDR_W: RAM read address; equals the current brick index.
- `x` out 8: pixel x to the VGA adapter.
- `y` out 7: pixel y to the VGA adapter.
- `colour` out 3: pixel colour to the VGA adapter.
- `plot` out 1: pixel write enable to the VGA adapter.
- `busy` out 1: high while a pass is in progress (FETCH, LOAD, DRAW).
- `done` out 1: one-cycle pulse when a pass completes.

## Operation
- States and transitions:
  - IDLE: `start`=1 → FETCH with index=0.
  - FETCH: `ram_address`=index → LOAD.
  - LOAD: latch `ram_q` into base_x, base_y, base_col; clear px and py → DRAW.
  - DRAW: advance px, py one pixel per cycle.
    - After the last pixel (px=BRICK_W-1, py=BRICK_H-1), if index=NUM_BRICKS-1 → DONE.
    - Otherwise index+1 → FETCH.
  - DONE: `done`=1 → IDLE.
- Pixel order: px is the inner loop (0..BRICK_W-1), py is the outer loop (0..BRICK_H-1).
- Pixel outputs in DRAW:
  - `x` = base_x + px, 8-bit, wraps mod 256.
  - `y` = base_y + py, 7-bit, wraps mod 128.
  - `colour` = base_col.
  - `plot`=1.
- Outside DRAW, `plot`=0.
- No clipping: off-screen coordinates are passed through unchanged.
- `start` asserted while `busy`, or in DONE, is ignored; it is not queued.
- The RAM is never written by this block. Its write port is owned by the store logic, and the two must not overlap in time.
- Reset values:
  - State IDLE; index, px, py, base_x, base_y, base_col all 0.
  - Outputs: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0, `ram_address`=0.
- Reset mid-pass aborts immediately at the next edge. No further plots occur and no `done` is issued.

## Timing
- `start` high at edge T (state IDLE):
  - FETCH in cycle T+1.
  - LOAD in T+2.
  - DRAW in T+3..T+2+BRICK_W*BRICK_H.
- Per brick: 2 + BRICK_W*BRICK_H cycles (66 with defaults). Brick k's first plot occurs at T+3+66k.
- `done` is high in cycle T+1+66*NUM_BRICKS (T+2641 for 40 bricks). IDLE follows one cycle later, and a new `start` is accepted there.
- RAM read latency is exactly 1 cycle: address presented in FETCH, data sampled in LOAD.

## Configuration
- `BRICK_SKIP_BLACK_EN` defined:
  - A record with colour 3'b000 (destroyed brick) is skipped in LOAD: no DRAW, and it goes straight to FETCH of the next index, or to DONE if it is the last.
  - A skipped brick costs 2 cycles and produces no plots.
- Not defined: black records are drawn like any other, as 64 plots with `colour`=0, which erases that area.

## Test plan
- Reset, then RAM loaded with the 40 default records (x steps by 16 to 143, y steps by 8, colour 3'b100), `start` pulsed:
  - exactly 2560 plots;
  - first plot (0,0,4) at T+3;
  - plot 17 at (0,1);
  - brick 1's first plot at (16,0) at T+69;
  - `done` at T+2641, one cycle wide.
- Single record {3'b010, 7'd120, 8'd250} with NUM_BRICKS=1:
  - x wraps 250..255 then 0..9;
  - y rows are 120..123;
  - colour 2 throughout.
- `start` re-pulsed at T+100 and again in the DONE cycle: both ignored, with exactly one `done` and 2560 plots. A `start` at T+2642 begins a new pass.
- `resetn` low at T+500: from the next edge `plot`=0, `busy`=0, all outputs 0, and no `done`. A new `start` restarts from address 0.
- Record 5 with colour 0:
  - with `BRICK_SKIP_BLACK_EN`: 2496 plots, `done` at T+2577;
  - without: 2560 plots, of which 64 have colour 0.

Source files
------------

// File: rtl/brick_renderer_if.sv
// Bus between the brick renderer and its environment: draw handshake,
// brick-RAM read port and the VGA adapter plot port.
interface brick_renderer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [17:0]       ram_q;
    logic [ADDR_W-1:0] ram_address;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        colour;
    logic              plot;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        input  ram_q,
        output ram_address,
        output x,
        output y,
        output colour,
        output plot,
        output busy,
        output done
    );

    modport slave (
        output start,
        output ram_q,
        input  ram_address,
        input  x,
        input  y,
        input  colour,
        input  plot,
        input  busy,
        input  done
    );
endinterface

// File: rtl/brick_renderer.sv
// Walks the brick RAM and rasterizes each record {colour, y, x} as a filled
// BRICK_W x BRICK_H rectangle. Optional macro: BRICK_SKIP_BLACK_EN (skip colour-0 records).
module brick_renderer #(
    parameter int NUM_BRICKS = 40,
    parameter int ADDR_W     = 8,
    parameter int BRICK_W    = 16,
    parameter int BRICK_H    = 4
) (
    input  logic             clk,
    input  logic             resetn,
    brick_renderer_if.master bus
);
    localparam int PX_W = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
    localparam int PY_W = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BRICKS - 1);
    localparam logic [PX_W-1:0]   PX_LAST  = PX_W'(BRICK_W - 1);
    localparam logic [PY_W-1:0]   PY_LAST  = PY_W'(BRICK_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [PX_W-1:0]   px_q, px_d;
    logic [PY_W-1:0]   py_q, py_d;
    logic [7:0]        base_x_q, base_x_d;
    logic [6:0]        base_y_q, base_y_d;
    logic [2:0]        base_col_q, base_col_d;

    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic [2:0]        colour_q, colour_d;
    logic              plot_q, plot_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;

    logic              skip_s;
    logic              last_brick_s;

`ifdef BRICK_SKIP_BLACK_EN
    assign skip_s = (bus.ram_q[17:15] == 3'b000);
`else
    assign skip_s = 1'b0;
`endif

    assign last_brick_s = (index_q == LAST_IDX);

    // Next-state logic: brick sequencing and pixel walk
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        px_d       = px_q;
        py_d       = py_q;
        base_x_d   = base_x_q;
        base_y_d   = base_y_q;
        base_col_d = base_col_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    index_d = {ADDR_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                base_x_d   = bus.ram_q[7:0];
                base_y_d   = bus.ram_q[14:8];
                base_col_d = bus.ram_q[17:15];
                px_d       = {PX_W{1'b0}};
                py_d       = {PY_W{1'b0}};
                if (!skip_s) begin
                    state_d = S_DRAW;
                end else if (last_brick_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    index_d = index_q + ADDR_W'(1'b1);
                end
            end

            S_DRAW: begin
                if (px_q != PX_LAST) begin
                    px_d = px_q + PX_W'(1'b1);
                end else begin
                    px_d = {PX_W{1'b0}};
                    if (py_q != PY_LAST) begin
                        py_d = py_q + PY_W'(1'b1);
                    end else begin
                        py_d = {PY_W{1'b0}};
                        if (last_brick_s) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FETCH;
                            index_d = index_q + ADDR_W'(1'b1);
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every port comes straight from a flop
    always_comb begin
        plot_d        = (state_d == S_DRAW);
        busy_d        = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_DRAW);
        done_d        = (state_d == S_DONE);
        ram_address_d = index_d;
        if (plot_d) begin
            x_d      = base_x_d + 8'(px_d);
            y_d      = base_y_d + 7'(py_d);
            colour_d = base_col_d;
        end else begin
            x_d      = 8'd0;
            y_d      = 7'd0;
            colour_d = 3'd0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            index_q       <= {ADDR_W{1'b0}};
            px_q          <= {PX_W{1'b0}};
            py_q          <= {PY_W{1'b0}};
            base_x_q      <= 8'd0;
            base_y_q      <= 7'd0;
            base_col_q    <= 3'd0;
            x_q           <= 8'd0;
            y_q           <= 7'd0;
            colour_q      <= 3'd0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ram_address_q <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            px_q          <= px_d;
            py_q          <= py_d;
            base_x_q      <= base_x_d;
            base_y_q      <= base_y_d;
            base_col_q    <= base_col_d;
            x_q           <= x_d;
            y_q           <= y_d;
            colour_q      <= colour_d;
            plot_q        <= plot_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ram_address_q <= ram_address_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.colour      = colour_q;
    assign bus.plot        = plot_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.ram_address = ram_address_q;

    brick_renderer_chk u_chk (
        .clk    (clk),
        .resetn (resetn),
        .plot   (plot_q),
        .busy   (busy_q),
        .done   (done_q)
    );
endmodule

// Output-relationship checks for brick_renderer.
module brick_renderer_chk (
    input logic clk,
    input logic resetn,
    input logic plot,
    input logic busy,
    input logic done
);
    // A pixel is only ever written while a pass is running
    plot_in_pass: assert property (@(posedge clk) disable iff (!resetn) plot |-> busy)
        else $error("plot asserted outside a pass");

    // done marks the end of a pass and lasts exactly one cycle
    done_not_busy: assert property (@(posedge clk) disable iff (!resetn) done |-> !busy)
        else $error("done asserted while busy");
    done_single: assert property (@(posedge clk) disable iff (!resetn) done |=> !done)
        else $error("done wider than one cycle");
endmodule

// File: tb/tb_brick_renderer.sv
// Directed bench for brick_renderer: 40-brick field, x/y wrap, ignored starts,
// mid-pass reset and black-brick handling (either build of BRICK_SKIP_BLACK_EN).
module tb_brick_renderer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    brick_renderer_if #(.ADDR_W(8)) bus_a ();
    brick_renderer_if #(.ADDR_W(8)) bus_b ();

    brick_renderer #(.NUM_BRICKS(40), .ADDR_W(8), .BRICK_W(16), .BRICK_H(4)) dut_a (
        .clk(clk), .resetn(resetn), .bus(bus_a));
    brick_renderer #(.NUM_BRICKS(1), .ADDR_W(8), .BRICK_W(16), .BRICK_H(4)) dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b));

    logic [17:0] mem_a [256];
    logic [17:0] rec_b = 18'd0;

    // One-cycle read latency brick RAMs
    always @(posedge clk) begin
        bus_a.ram_q <= mem_a[bus_a.ram_address];
        bus_b.ram_q <= (bus_b.ram_address == 8'd0) ? rec_b : 18'd0;
    end

    typedef struct {
        int         rel;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } plot_t;

    typedef struct {
        string      name;
        int         inst;
        int         idx;
        int         rel;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } vec_t;

    plot_t plots_a[$];
    plot_t plots_b[$];
    int    dones_a[$];
    int    dones_b[$];
    vec_t  vecs[$];

    int cyc = 0;
    int t_mark_a = 0;
    int t_mark_b = 0;
    int n_vec = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every plot and done with its cycle number relative to the start edge
    always @(negedge clk) begin
        if (bus_a.plot) plots_a.push_back('{cyc - t_mark_a + 1, bus_a.x, bus_a.y, bus_a.colour});
        if (bus_a.done) dones_a.push_back(cyc - t_mark_a + 1);
        if (bus_b.plot) plots_b.push_back('{cyc - t_mark_b + 1, bus_b.x, bus_b.y, bus_b.colour});
        if (bus_b.done) dones_b.push_back(cyc - t_mark_b + 1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vecs(input int inst);
        plot_t p;
        int sz;
        foreach (vecs[i]) begin
            if (vecs[i].inst == inst) begin
                sz = (inst == 0) ? plots_a.size() : plots_b.size();
                n_vec++;
                if (vecs[i].idx >= sz) begin
                    n_bad++;
                    $display("FAIL %s: plot %0d not captured (only %0d plots)", vecs[i].name, vecs[i].idx, sz);
                end else begin
                    p = (inst == 0) ? plots_a[vecs[i].idx] : plots_b[vecs[i].idx];
                    if (p.rel != vecs[i].rel || p.x !== vecs[i].x || p.y !== vecs[i].y || p.c !== vecs[i].c) begin
                        n_bad++;
                        $display("FAIL %s: got T+%0d (%0d,%0d,c%0d) expected T+%0d (%0d,%0d,c%0d)",
                                 vecs[i].name, p.rel, p.x, p.y, p.c, vecs[i].rel, vecs[i].x, vecs[i].y, vecs[i].c);
                    end
                end
            end
        end
    endtask

    task automatic start_a();
        @(negedge clk);
        plots_a.delete();
        dones_a.delete();
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        t_mark_a = cyc;
    endtask

    // Run until done (or budget), optionally pulsing start at one relative cycle
    task automatic run_a(input int budget, input int pulse_rel, output int done_rel, output int addr67);
        int rel;
        done_rel = -1;
        addr67 = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            rel = cyc - t_mark_a + 1;
            bus_a.start = (rel == pulse_rel);
            if (rel == 67) addr67 = int'(bus_a.ram_address);
            if (bus_a.done) begin
                done_rel = rel;
                break;
            end
        end
    endtask

    function automatic int outs_a();
        return int'({bus_a.x, bus_a.y, bus_a.colour, bus_a.plot, bus_a.busy, bus_a.done, bus_a.ram_address});
    endfunction

    function automatic int count_black_a();
        int n = 0;
        foreach (plots_a[i]) if (plots_a[i].c == 3'd0) n++;
        return n;
    endfunction

    initial begin
        int done_rel;
        int addr67;
        int n_before;
        int done_rel_b;

        vecs.push_back('{"a_first_plot",   0, 0,    3,    8'd0,   7'd0,   3'd4});
        vecs.push_back('{"a_row0_end",     0, 15,   18,   8'd15,  7'd0,   3'd4});
        vecs.push_back('{"a_plot17",       0, 16,   19,   8'd0,   7'd1,   3'd4});
        vecs.push_back('{"a_brick0_last",  0, 63,   66,   8'd15,  7'd3,   3'd4});
        vecs.push_back('{"a_brick1_first", 0, 64,   69,   8'd16,  7'd0,   3'd4});
        vecs.push_back('{"a_brick9_first", 0, 576,  597,  8'd0,   7'd8,   3'd4});
        vecs.push_back('{"a_last_plot",    0, 2559, 2640, 8'd63,  7'd35,  3'd4});
        vecs.push_back('{"b_first_plot",   1, 0,    3,    8'd250, 7'd120, 3'd2});
        vecs.push_back('{"b_x255",         1, 5,    8,    8'd255, 7'd120, 3'd2});
        vecs.push_back('{"b_x_wrap0",      1, 6,    9,    8'd0,   7'd120, 3'd2});
        vecs.push_back('{"b_row0_end",     1, 15,   18,   8'd9,   7'd120, 3'd2});
        vecs.push_back('{"b_row1_start",   1, 16,   19,   8'd250, 7'd121, 3'd2});
        vecs.push_back('{"b_last_plot",    1, 63,   66,   8'd9,   7'd123, 3'd2});

        for (int k = 0; k < 256; k++) begin
            if (k < 40) mem_a[k] = {3'b100, 7'(8 * (k / 9)), 8'(16 * (k % 9))};
            else        mem_a[k] = 18'd0;
        end
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_int("reset_outs_a", outs_a(), 0);
        check_int("reset_busy_b", int'(bus_b.busy), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check_int("idle_outs_a", outs_a(), 0);

        // Full 40-brick pass
        start_a();
        check_int("a_fetch_busy", int'(bus_a.busy), 1);
        check_int("a_fetch_addr", int'(bus_a.ram_address), 0);
        run_a(3000, -1, done_rel, addr67);
        check_int("a_done_rel", done_rel, 2641);
        check_int("a_addr_brick1", addr67, 1);
        @(negedge clk);
        check_int("a_done_width", int'(bus_a.done), 0);
        check_int("a_idle_busy", int'(bus_a.busy), 0);
        repeat (3) @(negedge clk);
        check_int("a_plot_count", plots_a.size(), 2560);
        check_int("a_done_count", dones_a.size(), 1);
        check_int("a_black_plots", count_black_a(), 0);
        check_vecs(0);

        // Starts at T+100 and in the DONE cycle are ignored; T+2642 starts a new pass
        start_a();
        run_a(3000, 100, done_rel, addr67);
        check_int("r_done_rel", done_rel, 2641);
        bus_a.start = 1'b1;
        @(negedge clk);
        check_int("r_idle_busy", int'(bus_a.busy), 0);
        check_int("r_done_width", int'(bus_a.done), 0);
        check_int("r_plot_count", plots_a.size(), 2560);
        check_int("r_done_count", dones_a.size(), 1);
        plots_a.delete();
        dones_a.delete();
        @(negedge clk);
        bus_a.start = 1'b0;
        t_mark_a = cyc;
        check_int("r_restart_busy", int'(bus_a.busy), 1);

        // Reset at T+500 of that new pass
        repeat (499) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check_int("m_reset_outs", outs_a(), 0);
        n_before = plots_a.size();
        check_int("m_plots_before_reset", n_before, 484);
        repeat (2800) @(negedge clk);
        check_int("m_plots_after_reset", plots_a.size(), n_before);
        check_int("m_no_done", dones_a.size(), 0);

        // Black record 5
        mem_a[5] = {3'b000, 7'd0, 8'd80};
        start_a();
        check_int("k_fetch_addr", int'(bus_a.ram_address), 0);
        check_int("k_fetch_busy", int'(bus_a.busy), 1);
        run_a(3000, -1, done_rel, addr67);
        repeat (3) @(negedge clk);
        check_int("k_first_plot", (plots_a.size() > 0) ? int'({plots_a[0].x, plots_a[0].y, plots_a[0].c}) : -1,
                  int'({8'd0, 7'd0, 3'd4}));
`ifdef BRICK_SKIP_BLACK_EN
        check_int("k_done_rel", done_rel, 2577);
        check_int("k_plot_count", plots_a.size(), 2496);
        check_int("k_black_plots", count_black_a(), 0);
        vecs.push_back('{"k_brick6_first", 2, 320, 335, 8'd96, 7'd0, 3'd4});
`else
        check_int("k_done_rel", done_rel, 2641);
        check_int("k_plot_count", plots_a.size(), 2560);
        check_int("k_black_plots", count_black_a(), 64);
        vecs.push_back('{"k_brick5_first", 2, 320, 333, 8'd80, 7'd0, 3'd0});
`endif
        foreach (vecs[i]) if (vecs[i].inst == 2) vecs[i].inst = 0;
        foreach (vecs[i]) if (vecs[i].name == "a_first_plot") vecs[i].inst = 3;
        foreach (vecs[i]) if (vecs[i].inst == 0 && vecs[i].idx != 320) vecs[i].inst = 3;
        check_vecs(0);
        check_int("k_done_count", dones_a.size(), 1);

        // Single wrapping record on the one-brick instance
        rec_b = {3'b010, 7'd120, 8'd250};
        @(negedge clk);
        plots_b.delete();
        dones_b.delete();
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        t_mark_b = cyc;
        done_rel_b = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_b.done) begin
                done_rel_b = cyc - t_mark_b + 1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        check_int("b_done_rel", done_rel_b, 67);
        check_int("b_plot_count", plots_b.size(), 64);
        check_int("b_done_count", dones_b.size(), 1);
        check_int("b_idle_busy", int'(bus_b.busy), 0);
        check_vecs(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
